// File: rtl/rsfq_jtl_pkg.sv
`default_nettype none
// =============================================================================
// Module      : rsfq_jtl_pkg
// Description : Shared types and helpers for the multi-channel RSFQ JTL model.
// Revision    : 1.0 - initial release
// =============================================================================
package rsfq_jtl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FAULT = 2'd2
    } jtl_state_e;

    localparam int ERR_CNT_W = 16;

    // Bits needed to encode the values 0 .. n_values-1 (never less than one).
    function automatic int cnt_width(input int n_values);
        return (n_values > 1) ? $clog2(n_values) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsfq_jtl_chan.sv
`default_nettype none
// =============================================================================
// Module      : rsfq_jtl_chan
// Description : One JTL line: state machine, critical-timing window counter and
//               delay pipeline. Optional macro: JTL_AUTO_RECOVER_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module rsfq_jtl_chan
    import rsfq_jtl_pkg::*;
#(
    parameter int DELAY = 4,
    parameter int CT    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    output logic o_out,
    output logic o_fault,
    output logic o_viol
);

    localparam int               c_cnt_w    = cnt_width(CT);
    localparam logic [c_cnt_w-1:0] c_win_load = c_cnt_w'(CT - 1);
    localparam logic [1:0]       c_st_idle  = IDLE;
    localparam logic [1:0]       c_st_busy  = BUSY;
    localparam logic [1:0]       c_st_fault = FAULT;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DELAY-1:0]   r_pipe;
    logic               r_out;
    logic               r_viol;
    logic               w_accept;
    logic               w_viol;
    logic [DELAY:0]     w_shift;

    assign w_accept = i_pulse && (r_state == c_st_idle);
    assign w_viol   = i_pulse && (r_state == c_st_busy);
    assign w_shift  = {r_pipe, w_accept};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_pipe  <= '0;
            r_out   <= 1'b0;
            r_viol  <= 1'b0;
        end else begin
            r_viol <= w_viol;
            // The oldest pipeline bit still emerges on the violation edge;
            // only younger pending pulses are flushed.
            if (r_state != c_st_fault) begin
                r_out <= r_out ^ r_pipe[DELAY-1];
            end
            r_pipe <= w_viol ? '0 : w_shift[DELAY-1:0];

            case (r_state)
                c_st_idle: begin
                    if (i_pulse) begin
                        r_cnt   <= c_win_load;
                        r_state <= (CT == 1) ? c_st_idle : c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (i_pulse) begin
                        r_cnt   <= c_win_load;
                        r_state <= c_st_fault;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                        if (r_cnt == c_cnt_w'(1)) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                c_st_fault: begin
`ifdef JTL_AUTO_RECOVER_EN
                    if (i_pulse) begin
                        r_cnt <= c_win_load;
                    end else if (r_cnt == '0) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
`else
                    r_state <= c_st_fault;
`endif
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign o_out   = r_out;
    assign o_fault = (r_state == c_st_fault);
    assign o_viol  = r_viol;

endmodule
`default_nettype wire

// File: rtl/rsfq_jtl_array.sv
`default_nettype none
// =============================================================================
// Module      : rsfq_jtl_array
// Description : CHANNELS independent toggle-encoded JTL lines with settle
//               blanking and aggregate error reporting.
//               Optional macro: JTL_AUTO_RECOVER_EN (fault auto-recovery).
// Revision    : 1.0 - initial release
// =============================================================================
module rsfq_jtl_array
    import rsfq_jtl_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DELAY    = 4,
    parameter int CT       = 5,
    parameter int SETTLE   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHANNELS-1:0]  in,
    output logic [CHANNELS-1:0]  out,
    output logic [CHANNELS-1:0]  fault,
    output logic                 err_vld,
    output logic [CHANNELS-1:0]  err_chan,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int                    c_settle_w    = cnt_width(SETTLE + 1);
    localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE);
    localparam int                    c_pop_w       = cnt_width(CHANNELS + 1);
    localparam int                    c_sum_w       = ERR_CNT_W + 1;

    logic [CHANNELS-1:0]   r_in_q;
    logic [c_settle_w-1:0] r_settle_cnt;
    logic [ERR_CNT_W-1:0]  r_err_count;
    logic                  w_settling;
    logic [CHANNELS-1:0]   w_pulse;
    logic [CHANNELS-1:0]   w_viol;
    logic [c_pop_w-1:0]    w_err_pop;
    logic [c_sum_w-1:0]    w_err_sum;

    assign w_settling = (r_settle_cnt != '0);
    assign w_pulse    = (in ^ r_in_q) & {CHANNELS{~w_settling}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q       <= in;
            r_settle_cnt <= c_settle_load;
        end else begin
            r_in_q <= in;
            if (w_settling) begin
                r_settle_cnt <= r_settle_cnt - c_settle_w'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            rsfq_jtl_chan #(
                .DELAY (DELAY),
                .CT    (CT)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .i_pulse (w_pulse[g]),
                .o_out   (out[g]),
                .o_fault (fault[g]),
                .o_viol  (w_viol[g])
            );
        end
    endgenerate

    always_comb begin
        w_err_pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_err_pop = w_err_pop + c_pop_w'(w_viol[i]);
        end
    end

    assign w_err_sum = {1'b0, r_err_count} + c_sum_w'(w_err_pop);

    // Saturate rather than wrap so a long fault storm never reads as clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_err_sum[ERR_CNT_W]) begin
            r_err_count <= '1;
        end else begin
            r_err_count <= w_err_sum[ERR_CNT_W-1:0];
        end
    end

    assign err_chan  = w_viol;
    assign err_vld   = |w_viol;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_rsfq_jtl_array.sv
`default_nettype none
// =============================================================================
// Module      : tb_rsfq_jtl_array
// Description : Scoreboard bench for rsfq_jtl_array with default parameters.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_rsfq_jtl_array;

    localparam int N     = 4;
    localparam int DELAY = 4;

    typedef struct {
        int ch;
        int at;
    } out_exp_t;

    typedef struct {
        int         at;
        logic [3:0] mask;
    } err_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  din = '0;
    logic [3:0]  out;
    logic [3:0]  fault;
    logic        err_vld;
    logic [3:0]  err_chan;
    logic [15:0] err_count;

    int         edge_n      = 0;
    logic       rst_at_edge = 1'b1;
    int         checks      = 0;
    int         passes      = 0;
    out_exp_t   out_q[$];
    err_exp_t   err_q[$];
    logic [3:0] prev_out    = '0;
    logic [3:0] chg;
    int         idx;
    err_exp_t   e;

    rsfq_jtl_array #(
        .CHANNELS (N),
        .DELAY    (DELAY),
        .CT       (5),
        .SETTLE   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .out       (out),
        .fault     (fault),
        .err_vld   (err_vld),
        .err_chan  (err_chan),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_n++;
        rst_at_edge = rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns once the next drive will be sampled at edge e.
    task automatic wait_to(input int e);
        while (edge_n < e - 1) step();
    endtask

    task automatic drive(input logic [3:0] mask, input logic [3:0] pass);
        din = din ^ mask;
        for (int i = 0; i < N; i++)
            if (pass[i]) out_q.push_back('{ch: i, at: edge_n + 1 + DELAY});
    endtask

    task automatic do_reset(output int rel);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        rel = edge_n;
    endtask

    // Monitor: compares every out toggle and every error strobe to the queues.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            prev_out = out;
        end else begin
            chg      = out ^ prev_out;
            prev_out = out;
            for (int i = 0; i < N; i++) begin
                if (chg[i]) begin
                    idx = -1;
                    for (int k = 0; k < out_q.size(); k++)
                        if (idx < 0 && out_q[k].ch == i) idx = k;
                    checks++;
                    if (idx < 0) begin
                        $display("FAIL out_toggle ch%0d: toggled at edge %0d, expected no toggle", i, edge_n);
                    end else begin
                        if (out_q[idx].at == edge_n) passes++;
                        else $display("FAIL out_toggle ch%0d: toggled at edge %0d, expected edge %0d",
                                      i, edge_n, out_q[idx].at);
                        out_q.delete(idx);
                    end
                end
            end
            if (err_vld) begin
                checks++;
                if (err_q.size() == 0) begin
                    $display("FAIL err_strobe: err_vld=1 err_chan=%b at edge %0d, expected no strobe",
                             err_chan, edge_n);
                end else begin
                    e = err_q.pop_front();
                    if (e.at == edge_n && e.mask == err_chan) passes++;
                    else $display("FAIL err_strobe: err_chan=%b at edge %0d, expected %b at edge %0d",
                                  err_chan, edge_n, e.mask, e.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1);
    end

    initial begin
        int r;
        int s;
        int u;

        do_reset(r);
        check("reset_out",       32'(out),       32'h0);
        check("reset_fault",     32'(fault),     32'h0);
        check("reset_err_vld",   32'(err_vld),   32'h0);
        check("reset_err_chan",  32'(err_chan),  32'h0);
        check("reset_err_count", 32'(err_count), 32'h0);

        // Pulses inside the settle window must vanish.
        drive(4'b0001, 4'b0000);
        step();
        drive(4'b0001, 4'b0000);
        step();
        drive(4'b0001, 4'b0000);

        // Legal single pulses, spacing-CT pair, and a spacing-4 violation.
        wait_to(r + 10);
        drive(4'b0111, 4'b0111);
        wait_to(r + 14);
        drive(4'b0100, 4'b0000);
        err_q.push_back('{at: r + 14, mask: 4'b0100});
        wait_to(r + 15);
        drive(4'b0010, 4'b0010);
        step();
        check("a_err_count", 32'(err_count), 32'd1);
        check("a_fault",     32'(fault),     32'h4);
        wait_to(r + 20);
        drive(4'b0100, 4'b0000);
        wait_to(r + 27);

        // Simultaneous violations on 0 and 3 while 1 and 2 keep flowing.
        do_reset(s);
        check("b_reset_out",       32'(out),       32'h0);
        check("b_reset_fault",     32'(fault),     32'h0);
        check("b_reset_err_count", 32'(err_count), 32'h0);
        wait_to(s + 6);
        drive(4'b1001, 4'b0000);
        wait_to(s + 8);
        drive(4'b1111, 4'b0110);
        err_q.push_back('{at: s + 8, mask: 4'b1001});
        step();
        step();
        check("b_err_count", 32'(err_count), 32'd2);
        check("b_fault",     32'(fault),     32'h9);
        wait_to(s + 13);
        drive(4'b0110, 4'b0110);
        wait_to(s + 14);
`ifdef JTL_AUTO_RECOVER_EN
        drive(4'b0001, 4'b0001);
        step();
        check("b_fault_recovered", 32'(fault), 32'h0);
`else
        drive(4'b0001, 4'b0000);
        step();
        check("b_fault_sticky", 32'(fault), 32'h9);
`endif
        wait_to(s + 22);

        // Reset two cycles after an accepted pulse discards it.
        do_reset(u);
        wait_to(u + 6);
        drive(4'b0010, 4'b0000);
        wait_to(u + 8);
        do_reset(u);
        check("c_reset_out",   32'(out),   32'h0);
        check("c_reset_fault", 32'(fault), 32'h0);
        repeat (12) step();

        check("out_queue_drained", 32'(out_q.size()), 32'd0);
        check("err_queue_drained", 32'(err_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rsfq_jtl_array.md
Name: rsfq_jtl_array

Overview:
- Cycle-based, multi-channel successor to the single-line JTL timing model.
- Carries CHANNELS independent toggle-encoded pulse lines. Each line has a programmable in-to-out delay, a critical-timing (minimum pulse spacing) check, per-channel fault handling and aggregate error reporting.
- Sits between RSFQ gate models in synthesizable/emulation netlists, where one clock cycle is one timing quantum.

Parameters:
- CHANNELS, 4, number of independent JTL lines (>=1).
- DELAY, 4, in-to-out latency in cycles (>=1).
- CT, 5, critical-timing window in cycles, counted from an accepted pulse (>=1; CT=1 disables violations).
- SETTLE, 4, cycles after reset release during which input pulses are ignored.

Ports:
- clk, input, 1, sole clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- in, input, CHANNELS, toggle-encoded pulses: any level change on bit i is one pulse on channel i.
- out, output, CHANNELS, toggle-encoded delayed pulses.
- fault, output, CHANNELS, channel i is in FAULT state.
- err_vld, output, 1, one-cycle strobe: at least one violation detected this cycle.
- err_chan, output, CHANNELS, mask of channels that violated this cycle; valid with err_vld, 0 otherwise.
- err_count, output, 16, saturating count of violation events.

Behaviour:
- Reset (rst=1 at edge):
  - out=0, fault=0, err_vld=0, err_chan=0, err_count=0.
  - Delay pipelines, window counters and settle counter cleared.
  - in_q<=in, so release never produces a spurious pulse.
- Pulse detect: p[i] = in[i] ^ in_q[i], evaluated at each edge; in_q<=in every cycle.
- Settle: for SETTLE cycles after rst deasserts, detected pulses are discarded silently and are neither accepted nor violations. in_q still tracks in.
- Per-channel FSM states: IDLE, BUSY, FAULT.
  - IDLE + pulse: accept. Insert pulse into DELAY-deep shift pipeline; load window counter with CT-1; go to BUSY, or stay IDLE if CT=1.
  - BUSY: counter decrements each cycle; at 0 go to IDLE.
  - BUSY + pulse: violation. The pulse is dropped, pending pipeline bits for the channel are flushed, and the channel goes to FAULT. err_vld=1 and err_chan[i]=1 on the next cycle.
  - FAULT: out[i] frozen at its current level; fault[i]=1; pulses ignored and not counted. Exit only via rst unless the optional feature is enabled.
- Latency: pulse sampled at edge t toggles out[i] at edge t+DELAY. Accepted pulses spaced >=CT cycles apart are reproduced with identical spacing.
- Pulse arriving exactly CT cycles after an accepted pulse is legal. One arriving at CT-1 cycles is a violation.
- err_count adds popcount(err_chan) each cycle and saturates at 16'hFFFF with no wrap.
- Channels are fully independent. Simultaneous pulses or violations on several channels are all handled in the same cycle.
- rst mid-flight discards all pipelined pulses; no out toggle is emitted for them.

Optional Feature:
- Macro: JTL_AUTO_RECOVER_EN.
- Defined: a channel in FAULT returns to IDLE after CT consecutive cycles with no input pulse on that channel; fault[i] drops in the same cycle. A pulse during the quiet period restarts the count and is not counted as a violation.
- Undefined: FAULT is sticky until rst.

Decomposition:
- Package rsfq_jtl_pkg holds:
  - enum jtl_state_e {IDLE, BUSY, FAULT}
  - localparam ERR_CNT_W=16
  - a function clog2-based width helper for the window counter.
- Sub-module rsfq_jtl_chan contains one channel's FSM, window counter and DELAY pipeline. It is instantiated CHANNELS times by generate.
- The top level holds in_q, the settle counter, error aggregation and the saturating counter.

Test Plan:
- Defaults. Release rst, wait 4 cycles, toggle in[0] at cycle 10 -> out[0] toggles at cycle 14; fault=0; err_vld never asserts.
- Toggle in[1] at cycles 10 and 15 (spacing=CT) -> out[1] toggles at 14 and 19; no error.
- Toggle in[2] at cycles 10 and 14 (spacing 4<CT) -> out[2] toggles once at 14 and then stays frozen; fault[2]=1; err_vld=1 and err_chan=4'b0100 for exactly one cycle; err_count=1.
- Toggle in[0] during settle cycles 1-3 -> no out change; no error.
- Violate on channels 0 and 3 in the same cycle -> err_chan=4'b1001, err_count+=2. Channels 1 and 2 continue passing pulses normally.
- Assert rst 2 cycles after an accepted pulse -> out and fault return to 0 and no delayed toggle appears. With JTL_AUTO_RECOVER_EN, a faulted channel clears after 5 quiet cycles and passes the next pulse with 4-cycle latency.
